peripheral_dbg_bmaster_b3_apb4: RTL

//  Wishbone B3 bus initiator for the debug path: accepts one command (dir, word address, length 1..16),

---
 rtl/peripheral_dbg_bmaster_b3_apb4.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/peripheral_dbg_bmaster_b3_apb4.sv
// peripheral_dbg_bmaster_b3_apb4: Wishbone B3 initiator running one classic or linear-burst debug command at a time
module peripheral_dbg_bmaster_b3_apb4 #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          apb4_clk_i,
  input  logic          apb4_rst_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [AW-1:0] cmd_adr_i,
  input  logic [3:0]    cmd_len_i,
  input  logic          wdata_valid_i,
  output logic          wdata_ready_o,
  input  logic [DW-1:0] wdata_i,
  output logic          rdata_valid_o,
  output logic [DW-1:0] rdata_o,
  output logic          done_o,
  output logic          err_o,
  output logic [AW-1:0] apb4_adr_o,
  output logic [DW-1:0] apb4_dat_o,
  output logic [3:0]    apb4_sel_o,
  output logic          apb4_we_o,
  output logic [1:0]    apb4_bte_o,
  output logic [2:0]    apb4_cti_o,
  output logic          apb4_cyc_o,
  output logic          apb4_stb_o,
  input  logic          apb4_ack_i,
  input  logic          apb4_err_i,
  input  logic          apb4_rty_i,
  input  logic [DW-1:0] apb4_dat_i
);
  typedef enum logic [1:0] {S_IDLE, S_BUS, S_END} state_t;
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT - 1);
  state_t        state_q, state_d;
  logic          we_q, we_d, cyc_q, cyc_d, stb_q, stb_d, full_q, full_d, classic_q, classic_d;
  logic          done_q, done_d, err_q, err_d, rdv_q, rdv_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_q, dat_d, rdata_q, rdata_d;
  logic [2:0]    cti_q, cti_d;
  logic [4:0]    beats_q, beats_d, wleft_q, wleft_d;
  logic [7:0]    to_q, to_d;
  logic          resp, ack_e, abort, wtake, last;
  assign resp          = apb4_ack_i | apb4_err_i | apb4_rty_i;
  assign ack_e         = stb_q & apb4_ack_i & ~apb4_err_i & ~apb4_rty_i;
  // err/rty beat ack; the timeout fires on the cycle the counter would hit TIMEOUT
  assign abort         = stb_q & (apb4_err_i | apb4_rty_i | (~resp & (to_q == TO_LIM)));
  assign last          = beats_q == 5'd1;
  assign cmd_ready_o   = state_q == S_IDLE;
  assign wdata_ready_o = (state_q == S_BUS) & we_q & (wleft_q != 5'd0) & (~full_q | ack_e);
  assign wtake         = wdata_valid_i & wdata_ready_o;
  assign apb4_adr_o    = adr_q;
  assign apb4_dat_o    = dat_q;
  assign apb4_sel_o    = 4'hF;
  assign apb4_we_o     = we_q;
  assign apb4_bte_o    = 2'b00;
  assign apb4_cti_o    = cti_q;
  assign apb4_cyc_o    = cyc_q;
  assign apb4_stb_o    = stb_q;
  assign rdata_valid_o = rdv_q;
  assign rdata_o       = rdata_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    cti_d     = cti_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    beats_d   = beats_q;
    wleft_d   = wleft_q;
    full_d    = full_q;
    classic_d = classic_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    done_d    = 1'b0;
    rdv_d     = 1'b0;
    to_d      = (!stb_q || resp) ? 8'd0 : to_q + 8'd1;
    case (state_q)
      S_IDLE: if (cmd_valid_i) begin
        state_d   = S_BUS;
        we_d      = cmd_we_i;
        adr_d     = cmd_adr_i & ~AW'(3);
        beats_d   = {1'b0, cmd_len_i} + 5'd1;
        wleft_d   = cmd_we_i ? {1'b0, cmd_len_i} + 5'd1 : 5'd0;
        classic_d = cmd_len_i == 4'd0;
        cti_d     = cmd_len_i == 4'd0 ? 3'b000 : 3'b010;
        cyc_d     = 1'b1;
        stb_d     = !cmd_we_i;
        full_d    = 1'b0;
        err_d     = 1'b0;
      end
      S_BUS: if (abort) begin
        state_d = S_END;
        done_d  = 1'b1;
        err_d   = 1'b1;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        full_d  = 1'b0;
        wleft_d = 5'd0;
      end else begin
        if (ack_e) begin
          adr_d   = adr_q + AW'(4);
          beats_d = beats_q - 5'd1;
          cti_d   = classic_q ? 3'b000 : beats_q == 5'd2 ? 3'b111 : 3'b010;
          rdv_d   = !we_q;
          rdata_d = we_q ? rdata_q : apb4_dat_i;
          if (last) begin
            state_d = S_END;
            done_d  = 1'b1;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
          end
        end
        // write strobe follows the one-word buffer so an empty buffer idles the burst
        if (we_q) begin
          full_d  = wtake || (full_q && !ack_e);
          stb_d   = full_d;
          dat_d   = wtake ? wdata_i : dat_q;
          wleft_d = wleft_q - {4'd0, wtake};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge apb4_clk_i) begin
    if (!apb4_rst_i) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      cti_q     <= 3'b000;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      beats_q   <= 5'd0;
      wleft_q   <= 5'd0;
      full_q    <= 1'b0;
      classic_q <= 1'b0;
      to_q      <= 8'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdv_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      cti_q     <= cti_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      beats_q   <= beats_d;
      wleft_q   <= wleft_d;
      full_q    <= full_d;
      classic_q <= classic_d;
      to_q      <= to_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdv_q     <= rdv_d;
      rdata_q   <= rdata_d;
    end
  end
endmodule
